// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Free-running raster counter with registered, zero-skew sync,
//               blank and pulse decode. Optional macro VGA_TIMING_SYNC_DELAY_EN
//               delays hs/vs by one pixel clock.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic       line_end
);

    localparam logic [9:0] c_H_LAST     = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_V_LAST     = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] c_H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] c_V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] c_H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] c_H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] c_V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] c_V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] r_hc;
    logic [9:0] r_vc;
    logic [9:0] w_hc_nxt;
    logic [9:0] w_vc_nxt;
    logic       w_h_wrap;
    logic       r_blank;
    logic       r_hs;
    logic       r_vs;
    logic       r_frame_start;
    logic       r_line_end;

    always_comb begin
        w_h_wrap = (r_hc == c_H_LAST);
        w_hc_nxt = w_h_wrap ? 10'd0 : r_hc + 10'd1;
        w_vc_nxt = r_vc;
        if (w_h_wrap) begin
            w_vc_nxt = (r_vc == c_V_LAST) ? 10'd0 : r_vc + 10'd1;
        end
    end

    // Decode the next position so every flag lines up with the counter it describes.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hc          <= c_H_LAST;
            r_vc          <= c_V_LAST;
            r_blank       <= 1'b0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_frame_start <= 1'b0;
            r_line_end    <= 1'b0;
        end else begin
            r_hc          <= w_hc_nxt;
            r_vc          <= w_vc_nxt;
            r_blank       <= (w_hc_nxt < c_H_VIS) && (w_vc_nxt < c_V_VIS);
            r_hs          <= !((w_hc_nxt >= c_H_SYNC_BEG) && (w_hc_nxt < c_H_SYNC_END));
            r_vs          <= !((w_vc_nxt >= c_V_SYNC_BEG) && (w_vc_nxt < c_V_SYNC_END));
            r_frame_start <= (w_hc_nxt == 10'd0) && (w_vc_nxt == 10'd0);
            r_line_end    <= (w_hc_nxt == c_H_LAST);
        end
    end

    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign blank       = r_blank;
    assign frame_start = r_frame_start;
    assign line_end    = r_line_end;

`ifdef VGA_TIMING_SYNC_DELAY_EN
    // Extra stage matches the one-cycle lag of the renderers' registered RGB.
    logic r_hs_d;
    logic r_vs_d;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hs_d <= 1'b1;
            r_vs_d <= 1'b1;
        end else begin
            r_hs_d <= r_hs;
            r_vs_d <= r_vs;
        end
    end

    assign hs = r_hs_d;
    assign vs = r_vs_d;
`else
    assign hs = r_hs;
    assign vs = r_vs;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed bench; full-size instance for line timing and reset,
//               reduced-size instance (32x20 raster) for frame-level timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

`ifdef VGA_TIMING_SYNC_DELAY_EN
    localparam int SD = 1;
`else
    localparam int SD = 0;
`endif

    logic       clk;
    logic       rst;
    logic [9:0] b_x, b_y, s_x, s_y;
    logic       b_blank, b_hs, b_vs, b_fs, b_le;
    logic       s_blank, s_hs, s_vs, s_fs, s_le;

    int n_checks = 0;
    int n_errors = 0;

    vga_timing_gen u_dut (
        .vga_clk     (clk),
        .reset       (rst),
        .DrawX       (b_x),
        .DrawY       (b_y),
        .blank       (b_blank),
        .hs          (b_hs),
        .vs          (b_vs),
        .frame_start (b_fs),
        .line_end    (b_le)
    );

    // Small raster: H 16/4/8/4 = 32, V 12/2/2/4 = 20, frame = 640 cycles.
    vga_timing_gen #(
        .H_VISIBLE (16), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_VISIBLE (12), .V_FP (2), .V_SYNC (2), .V_BP (4)
    ) u_small (
        .vga_clk     (clk),
        .reset       (rst),
        .DrawX       (s_x),
        .DrawY       (s_y),
        .blank       (s_blank),
        .hs          (s_hs),
        .vs          (s_vs),
        .frame_start (s_fs),
        .line_end    (s_le)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_x"},     32'(b_x), 32'd799);
        check_val({tag, "_y"},     32'(b_y), 32'd524);
        check_val({tag, "_blank"}, 32'(b_blank), 32'd0);
        check_val({tag, "_hs"},    32'(b_hs), 32'd1);
        check_val({tag, "_vs"},    32'(b_vs), 32'd1);
        check_val({tag, "_fs"},    32'(b_fs), 32'd0);
        check_val({tag, "_le"},    32'(b_le), 32'd0);
        check_val({tag, "_sx"},    32'(s_x), 32'd31);
        check_val({tag, "_sy"},    32'(s_y), 32'd19);
    endtask

    task automatic check_origin(input string tag);
        check_val({tag, "_x"},     32'(b_x), 32'd0);
        check_val({tag, "_y"},     32'(b_y), 32'd0);
        check_val({tag, "_blank"}, 32'(b_blank), 32'd1);
        check_val({tag, "_fs"},    32'(b_fs), 32'd1);
        check_val({tag, "_hs"},    32'(b_hs), 32'd1);
        check_val({tag, "_le"},    32'(b_le), 32'd0);
        check_val({tag, "_sx"},    32'(s_x), 32'd0);
        check_val({tag, "_sfs"},   32'(s_fs), 32'd1);
    endtask

    int bx, by, sx, sy, j;
    logic e_hs, e_vs, e_shs, e_svs;
    int bad_x, bad_y, bad_blank, bad_hs, bad_vs, bad_fs, bad_le;
    int hs_low, hs_first, hs_last, blank_fall_x, le_cnt, le_x;
    int s_fs_cnt, s_fs_last, s_fs_period, s_le_last, s_le_period;
    int s_vs_low, s_blank_cnt, s_vs_bad_edge;
    logic prev_blank, prev_svs;
    int wait_cnt;

    initial begin
        bad_x = 0; bad_y = 0; bad_blank = 0; bad_hs = 0; bad_vs = 0; bad_fs = 0; bad_le = 0;
        hs_low = 0; hs_first = -1; hs_last = -1; blank_fall_x = -1; le_cnt = 0; le_x = -1;
        s_fs_cnt = 0; s_fs_last = -1; s_fs_period = -1; s_le_last = -1; s_le_period = -1;
        s_vs_low = 0; s_blank_cnt = 0; s_vs_bad_edge = 0;
        prev_blank = 1'b0; prev_svs = 1'b1;

        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_reset_state("rst_hold");

        rst = 1'b0;
        @(negedge clk);
        check_origin("release");

        // Cycle i after release; two full small frames and the first full-size line.
        for (int i = 0; i < 1280; i++) begin
            bx = i % 800;  by = i / 800;
            sx = i % 32;   sy = (i / 32) % 20;
            j  = i - SD;
            e_hs  = (j < 0) ? 1'b1 : !(((j % 800) >= 656) && ((j % 800) < 752));
            e_vs  = (j < 0) ? 1'b1 : !(((j / 800) >= 490) && ((j / 800) < 492));
            e_shs = (j < 0) ? 1'b1 : !(((j % 32) >= 20) && ((j % 32) < 28));
            e_svs = (j < 0) ? 1'b1 : !((((j / 32) % 20) >= 14) && (((j / 32) % 20) < 16));

            if (b_x !== 10'(bx) || s_x !== 10'(sx)) bad_x++;
            if (b_y !== 10'(by) || s_y !== 10'(sy)) bad_y++;
            if (b_blank !== ((bx < 640) && (by < 480)) || s_blank !== ((sx < 16) && (sy < 12))) bad_blank++;
            if (b_hs !== e_hs || s_hs !== e_shs) bad_hs++;
            if (b_vs !== e_vs || s_vs !== e_svs) bad_vs++;
            if (b_fs !== (bx == 0 && by == 0) || s_fs !== (sx == 0 && sy == 0)) bad_fs++;
            if (b_le !== (bx == 799) || s_le !== (sx == 31)) bad_le++;

            if (i < 800 && b_hs === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = bx;
                hs_last = bx;
            end
            if (i > 0 && prev_blank && b_blank === 1'b0 && blank_fall_x < 0) blank_fall_x = bx;
            if (b_le === 1'b1) begin le_cnt++; le_x = bx; end
            if (s_fs === 1'b1) begin
                s_fs_cnt++;
                if (s_fs_last >= 0) s_fs_period = i - s_fs_last;
                s_fs_last = i;
            end
            if (s_le === 1'b1) begin
                if (s_le_last >= 0) s_le_period = i - s_le_last;
                s_le_last = i;
            end
            if (s_vs === 1'b0) s_vs_low++;
            if (s_blank === 1'b1) s_blank_cnt++;
            if (i > 0 && s_vs !== prev_svs && sx != SD) s_vs_bad_edge++;
            prev_blank = b_blank;
            prev_svs   = s_vs;
            @(negedge clk);
        end

        check_val("track_x",     32'(bad_x), 32'd0);
        check_val("track_y",     32'(bad_y), 32'd0);
        check_val("track_blank", 32'(bad_blank), 32'd0);
        check_val("track_hs",    32'(bad_hs), 32'd0);
        check_val("track_vs",    32'(bad_vs), 32'd0);
        check_val("track_fs",    32'(bad_fs), 32'd0);
        check_val("track_le",    32'(bad_le), 32'd0);
        check_val("hs_low_cycles", 32'(hs_low), 32'd96);
        check_val("hs_first_x",    32'(hs_first), 32'(656 + SD));
        check_val("hs_last_x",     32'(hs_last), 32'(751 + SD));
        check_val("blank_fall_x",  32'(blank_fall_x), 32'd640);
        check_val("le_count",      32'(le_cnt), 32'd1);
        check_val("le_x",          32'(le_x), 32'd799);
        check_val("s_fs_count",    32'(s_fs_cnt), 32'd2);
        check_val("s_frame_period", 32'(s_fs_period), 32'd640);
        check_val("s_line_period", 32'(s_le_period), 32'd32);
        check_val("s_vs_low",      32'(s_vs_low), 32'd128);
        check_val("s_blank_high",  32'(s_blank_cnt), 32'd384);
        check_val("s_vs_edge_x",   32'(s_vs_bad_edge), 32'd0);

        // Mid-line reset: big counter sits at (480,1) here; wait for DrawX==300.
        wait_cnt = 0;
        while (b_x !== 10'd300 && wait_cnt < 2000) begin
            @(negedge clk);
            wait_cnt++;
        end
        check_val("reach_x300", 32'(b_x), 32'd300);
        check_val("reach_y2",   32'(b_y), 32'd2);

        rst = 1'b1;
        @(negedge clk);
        check_reset_state("mid_rst1");
        repeat (2) @(negedge clk);
        check_reset_state("mid_rst3");
        rst = 1'b0;
        @(negedge clk);
        check_origin("restart");

        repeat (10) @(negedge clk);
        check_val("post_x", 32'(b_x), 32'd10);
        check_val("post_sx", 32'(s_x), 32'd10);
        check_val("post_fs", 32'(b_fs), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
